layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Upstream sequencer for one fully-connected layer. Accepts an input vector via valid/ready
//  and fires the per-neuron controller once per neuron, walking neuron_sel 0..N_NEURONS-1.
//  Captures each neuron result through ReLU into an output buffer, then presents the whole
//  layer vector downstream via valid/ready. A watchdog aborts on a missing neuron_ready.
// PARAMETERS
//  N_NEURONS  10  neurons in the layer; neuron_sel width = $clog2(N_NEURONS)
//  N_INPUTS   10  inputs per neuron; same value as the neuron controller's N
//  DW         8   signed data width of neuron_result and each output element
//  TIMEOUT    64  max cycles in WAIT before abort; must exceed N_INPUTS+2
// PORTS
//  clk            in   1                  clock, rising edge
//  rst            in   1                  asynchronous reset, active-low
//  in_valid       in   1                  upstream input vector available
//  in_ready       out  1                  sequencer can accept a vector
//  neuron_start   out  1                  one-cycle start pulse to neuron controller
//  neuron_ready   in   1                  one-cycle done pulse from neuron controller
//  neuron_result  in   DW                 signed neuron sum, valid while neuron_ready=1
//  neuron_sel     out  $clog2(N_NEURONS)  index of neuron in progress (weight bank select)
//  out_valid      out  1                  layer output vector valid
//  out_ready      in   1                  downstream accepts vector
//  out_data       out  N_NEURONS*DW       element k at [k*DW +: DW]
//  busy           out  1                  1 in any state other than IDLE
//  error          out  1                  sticky timeout flag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; neuron_sel=0, out_data=0, error=0, wdog=0.
//   Outputs under reset: in_ready=1, busy=0; neuron_start=0, out_valid=0.
//  FSM states: IDLE, START, WAIT, OUT (Moore outputs; datapath updates on clk edge).
//  IDLE : in_ready=1. in_valid&in_ready -> START; neuron_sel<=0, error<=0.
//  START: neuron_start=1 for exactly one cycle; wdog<=0; -> WAIT.
//  WAIT : wdog increments each cycle.
//   neuron_ready=1 -> out_data[neuron_sel] <= relu(neuron_result).
//    If neuron_sel==N_NEURONS-1, go to OUT; otherwise neuron_sel++ and go to START.
//   wdog==TIMEOUT-1 w/o ready -> error<=1, neuron_sel<=0, -> IDLE; out_data left partial.
//  OUT  : out_valid=1; out_data stable. out_ready=1 -> IDLE, neuron_sel<=0.
//   out_ready may be high before/at rise; handshake completes in first cycle out_valid=1.
//  relu(x): x[DW-1]=1 -> 0, else x unchanged (no width change).
//  neuron_ready outside WAIT is ignored; neuron_result is sampled only on neuron_ready in WAIT.
//  in_valid while busy: ignored, in_ready=0, no back-pressure side effects.
//  Latency with a conforming neuron (ready N_INPUTS+2 cycles after start):
//   out_valid rises N_NEURONS*(N_INPUTS+3)+1 cycles after the input handshake edge.
//   131 cycles with default parameters.
//  out_data holds last values after OUT handshake until overwritten by next layer pass.
//  rst asserted mid-operation: immediate return to reset values; no pulse completes.
//  error stays set through IDLE until the next accepted input vector clears it.
// TESTING
//  Reset: rst=0 during WAIT -> in_ready=1, busy=0, neuron_start=0, out_valid=0, out_data=0.
//  Nominal run, defaults:
//   neuron model returns result=k+1 for neuron k.
//   -> 10 start pulses, neuron_sel 0..9; out_data[k]=k+1; out_valid 131 cycles after accept.
//  ReLU: results alternate 8'sh85 / 8'sh7F -> elements 0x00 / 0x7F respectively.
//  Back-pressure: out_ready=0 for 20 cycles in OUT.
//   -> out_valid and out_data held; in_valid ignored (in_ready=0) until handshake.
//  Timeout: neuron model never raises ready at neuron_sel=3.
//   -> error=1 after 64 WAIT cycles, IDLE, in_ready=1; next accept clears error.
//  Stray pulse: neuron_ready=1 during IDLE/START/OUT -> no out_data change, no state change.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Handshake and neuron-control bundle for layer_sequencer.
// master = sequencer side, slave = upstream/neuron/downstream side.
interface layer_sequencer_if #(
  parameter int N_NEURONS = 10,
  parameter int DW        = 8
);
  localparam int SELW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic                    neuron_start;
  logic                    neuron_ready;
  logic signed [DW-1:0]    neuron_result;
  logic [SELW-1:0]         neuron_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_NEURONS*DW-1:0] out_data;
  logic                    busy;
  logic                    error;

  modport master (
    input  in_valid, neuron_ready, neuron_result, out_ready,
    output in_ready, neuron_start, neuron_sel,
    output out_valid, out_data, busy, error
  );

  modport slave (
    output in_valid, neuron_ready, neuron_result, out_ready,
    input  in_ready, neuron_start, neuron_sel,
    input  out_valid, out_data, busy, error
  );
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: fires one neuron at a time, ReLU-captures results.
// Ports: clk, rst (async active-low), lyr (master modport of layer_sequencer_if).
module layer_sequencer #(
  parameter int N_NEURONS = 10,
  parameter int N_INPUTS  = 10,
  parameter int DW        = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.master  lyr
);
  localparam int SELW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  // A watchdog shorter than one conforming neuron would abort every pass.
  localparam int TO_EFF = (TIMEOUT > N_INPUTS + 2) ? TIMEOUT : N_INPUTS + 3;
  localparam int WDW = $clog2(TO_EFF);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(N_NEURONS - 1);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TO_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [SELW-1:0]         sel_q, sel_d;
  logic [WDW-1:0]          wdog_q, wdog_d;
  logic [N_NEURONS*DW-1:0] data_q, data_d;
  logic                    err_q, err_d;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      wdog_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wdog_q  <= wdog_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wdog_d  = wdog_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (lyr.in_valid) begin
          state_d = S_START;
          sel_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (lyr.neuron_ready) begin
          data_d[sel_q*DW +: DW] = relu(lyr.neuron_result);
          if (sel_q == SEL_LAST) begin
            state_d = S_OUT;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = S_START;
          end
        end else if (wdog_q == WD_LAST) begin
          // Partial results stay in data_q on abort.
          err_d   = 1'b1;
          sel_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (lyr.out_ready) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lyr.in_ready     = (state_q == S_IDLE);
  assign lyr.busy         = (state_q != S_IDLE);
  assign lyr.neuron_start = (state_q == S_START);
  assign lyr.out_valid    = (state_q == S_OUT);
  assign lyr.neuron_sel   = sel_q;
  assign lyr.out_data     = data_q;
  assign lyr.error        = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with an event-level layer model.
// Ports: none (top-level bench).
module tb_layer_sequencer;
  localparam int NN = 10;
  localparam int NI = 10;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int VW = NN * DW;
  localparam logic [VW-1:0] LIT_NOM  = 80'h0a090807060504030201;
  localparam logic [VW-1:0] LIT_RELU = 80'h7f007f007f007f007f00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_sequencer_if #(.N_NEURONS(NN), .DW(DW)) bus ();

  layer_sequencer #(
    .N_NEURONS(NN),
    .N_INPUTS (NI),
    .DW       (DW),
    .TIMEOUT  (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lyr(bus)
  );

  logic          in_valid;
  logic          out_ready;
  logic          nm_ready;
  logic [DW-1:0] nm_res;
  logic          stray;
  logic [DW-1:0] stray_res;
  int            mode;
  int            drop_k;
  int            exp_lat;
  int            exp_err_lat;
  logic [VW-1:0] exp_lit;

  assign bus.in_valid      = in_valid;
  assign bus.out_ready     = out_ready;
  assign bus.neuron_ready  = nm_ready | stray;
  assign bus.neuron_result = stray ? stray_res : nm_res;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [VW-1:0] act,
                      input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Neuron stand-in: answers 12 cycles after each start pulse.
  int cd = 0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      cd       = 0;
      nm_ready = 1'b0;
    end else begin
      if (cd > 0) begin
        cd--;
        nm_ready = (cd == 0);
      end else begin
        nm_ready = 1'b0;
      end
      if (bus.neuron_start && int'(bus.neuron_sel) != drop_k) begin
        cd = NI + 2;
        if (mode == 0) nm_res = DW'(int'(bus.neuron_sel) + 1);
        else nm_res = bus.neuron_sel[0] ? 8'h7f : 8'h85;
      end
    end
  end

  // Layer model: what a pass must show, from the behavioural rules.
  logic [DW-1:0] m_data [NN];
  bit m_busy, m_start, m_wait, m_outv, m_err;
  int m_cnt, m_wc;
  int cyc = 0, acc_cyc = 0, starts = 0;
  bit seen_ov, seen_err;

  function automatic logic [VW-1:0] m_pack();
    logic [VW-1:0] v;
    for (int i = 0; i < NN; i++) v[i*DW +: DW] = m_data[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] relu_m(input logic signed [DW-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_start", bus.neuron_start, 1'b0);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chkv("rst_out_data", bus.out_data, '0);
      chk1("rst_error", bus.error, 1'b0);
      for (int i = 0; i < NN; i++) m_data[i] = '0;
      m_busy = 0; m_start = 0; m_wait = 0;
      m_outv = 0; m_err = 0; m_cnt = 0; m_wc = 0;
    end else begin
      chk1("in_ready", bus.in_ready, !m_busy);
      chk1("busy", bus.busy, m_busy);
      chk1("neuron_start", bus.neuron_start, m_start);
      chki("neuron_sel", int'(bus.neuron_sel), m_outv ? NN - 1 : m_cnt);
      chk1("out_valid", bus.out_valid, m_outv);
      chkv("out_data", bus.out_data, m_pack());
      chk1("error", bus.error, m_err);
      if (bus.neuron_start) starts++;
      if (bus.out_valid && !seen_ov) begin
        seen_ov = 1;
        chki("latency", cyc - acc_cyc, exp_lat);
        chkv("layer_vector", bus.out_data, exp_lit);
        chki("start_count", starts, NN);
      end
      if (bus.error && !seen_err) begin
        seen_err = 1;
        chki("abort_latency", cyc - acc_cyc, exp_err_lat);
      end
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_err = 0; m_cnt = 0; m_start = 1;
          acc_cyc = cyc; starts = 0; seen_ov = 0; seen_err = 0;
        end
      end else if (m_start) begin
        m_start = 0; m_wait = 1; m_wc = 0;
      end else if (m_wait) begin
        if (bus.neuron_ready) begin
          m_data[m_cnt] = relu_m(bus.neuron_result);
          m_wait = 0;
          if (m_cnt == NN - 1) m_outv = 1;
          else begin
            m_cnt++;
            m_start = 1;
          end
        end else if (m_wc == TO - 1) begin
          m_err = 1; m_busy = 0; m_wait = 0; m_cnt = 0;
        end else begin
          m_wc++;
        end
      end else if (m_outv && out_ready) begin
        m_outv = 0; m_busy = 0; m_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int lim);
    int n = 0;
    while (!bus.out_valid) begin
      step();
      n++;
      if (n > lim) begin
        $display("FAIL wait_out_valid: got none want rise within %0d", lim);
        $fatal(1);
      end
    end
  endtask

  task automatic wait_err(input int lim);
    int n = 0;
    while (!bus.error) begin
      step();
      n++;
      if (n > lim) begin
        $display("FAIL wait_error: got none want rise within %0d", lim);
        $fatal(1);
      end
    end
  endtask

  task automatic pulse_stray(input logic [DW-1:0] v);
    stray = 1'b1;
    stray_res = v;
    step();
    stray = 1'b0;
  endtask

  initial begin
    in_valid = 0; out_ready = 1; nm_ready = 0; nm_res = '0;
    stray = 0; stray_res = '0; mode = 0; drop_k = -1;
    exp_lat = 131; exp_err_lat = 105; exp_lit = LIT_NOM;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Nominal pass, out_ready already high.
    accept();
    wait_ov(300);
    step();
    pulse_stray(8'h11);

    // ReLU pass with back-pressure, stray pulse and in_valid during OUT.
    mode = 1; out_ready = 0; exp_lit = LIT_RELU;
    accept();
    wait_ov(300);
    pulse_stray(8'h33);
    in_valid = 1'b1;
    repeat (19) step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    // Stray pulse while in START.
    mode = 0; exp_lit = LIT_NOM;
    accept();
    pulse_stray(8'h22);
    wait_ov(300);
    step();

    // Neuron 3 never answers.
    mode = 1; drop_k = 3;
    accept();
    wait_err(300);
    repeat (3) step();
    drop_k = -1;

    // Next accept clears error and runs normally.
    mode = 0; exp_lit = LIT_NOM;
    accept();
    wait_ov(300);
    step();

    // Reset in the middle of WAIT.
    accept();
    repeat (20) step();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Recovery pass after reset.
    accept();
    wait_ov(300);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
